// File: rtl/update_pattern_pkg.sv
// Shared definitions for the lane-pattern generator: pattern width, the
// value that replaces the all-zero state, and the next-pattern step.
package update_pattern_pkg;

  localparam int PAT_W = 4;
  localparam logic [PAT_W-1:0] PAT_ZERO_ESCAPE = 4'b0001;

  // 4-bit maximal-length LFSR step (taps 3,2); zero is forced to 0001 so
  // the generator can never lock up in the all-zero state.
  function automatic logic [PAT_W-1:0] next_pattern(input logic [PAT_W-1:0] p);
    if (p == '0) begin
      return PAT_ZERO_ESCAPE;
    end
    return {p[2:0], p[3] ^ p[2]};
  endfunction

endpackage

// File: rtl/update_pattern_window.sv
// ROWS-deep shift register of patterns. Row 0 is the hit row, row ROWS-1
// receives the newly generated pattern on each shift.
module pattern_window
  import update_pattern_pkg::*;
#(
  parameter int ROWS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift,
  input  logic [PAT_W-1:0]      topRow,
  output logic [PAT_W*ROWS-1:0] window
);

  // Shift rows toward row 0 and load the new pattern into the top row.
  always_ff @(posedge clk) begin
    if (rst) begin
      window <= '0;
    end else if (shift) begin
      for (int unsigned r = 0; r + 1 < ROWS; r++) begin
        window[PAT_W*r +: PAT_W] <= window[PAT_W*(r+1) +: PAT_W];
      end
      window[PAT_W*(ROWS-1) +: PAT_W] <= topRow;
    end
  end

endmodule

// File: rtl/update_pattern.sv
// Lane-pattern generator: combinational next-pattern port plus a clocked
// sequencer maintaining a scrolling window of upcoming rows.
module update_pattern
  import update_pattern_pkg::*;
#(
  parameter int ROWS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAT_W-1:0]      currentPattern,
  output logic [PAT_W-1:0]      nextPattern,
  input  logic                  step,
  input  logic                  seed_load,
  input  logic [PAT_W-1:0]      seed,
  output logic [PAT_W*ROWS-1:0] window,
  output logic [PAT_W-1:0]      gen_state,
  output logic [7:0]            step_count
);

  logic [PAT_W-1:0] genNext;
  logic             doShift;

  // Combinational next-pattern function and the generator's successor.
  always_comb begin
    nextPattern = next_pattern(currentPattern);
    genNext     = next_pattern(gen_state);
  end

  // A seed load takes precedence over a simultaneous step.
  assign doShift = step & ~seed_load;

  // Generator state and accepted-step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_state  <= '0;
      step_count <= '0;
    end else if (seed_load) begin
      gen_state <= seed;
    end else if (step) begin
      gen_state  <= genNext;
      step_count <= step_count + 8'd1;
    end
  end

  pattern_window #(
    .ROWS(ROWS)
  ) uWindow (
    .clk    (clk),
    .rst    (rst),
    .shift  (doShift),
    .topRow (genNext),
    .window (window)
  );

endmodule

// File: tb/tb_update_pattern.sv
// Self-checking bench for update_pattern (ROWS=4): table-driven checks of
// the combinational function plus a scoreboarded sequencer model.
module tb_update_pattern;

  localparam int ROWS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [3:0]          currentPattern = '0;
  logic [3:0]          nextPattern;
  logic                step = 1'b0;
  logic                seedLoad = 1'b0;
  logic [3:0]          seed = '0;
  logic [4*ROWS-1:0]   window;
  logic [3:0]          genState;
  logic [7:0]          stepCount;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4*ROWS-1:0] win;
    logic [3:0]        gen;
    logic [7:0]        cnt;
  } seqExp_t;

  typedef struct {
    logic [3:0] cp;
    logic [3:0] np;
  } combVec_t;

  seqExp_t sb[$];

  // Reference model state
  logic [4*ROWS-1:0] mWin;
  logic [3:0]        mGen;
  logic [7:0]        mCnt;

  update_pattern #(
    .ROWS(ROWS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .currentPattern (currentPattern),
    .nextPattern    (nextPattern),
    .step           (step),
    .seed_load      (seedLoad),
    .seed           (seed),
    .window         (window),
    .gen_state      (genState),
    .step_count     (stepCount)
  );

  always #5 clk = ~clk;

  // Successor table taken from the documented sequence, not from the formula.
  function automatic logic [3:0] fRef(input logic [3:0] p);
    case (p)
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h4;
      4'h4: return 4'h9;  4'h9: return 4'h3;  4'h3: return 4'h6;
      4'h6: return 4'hD;  4'hD: return 4'hA;  4'hA: return 4'h5;
      4'h5: return 4'hB;  4'hB: return 4'h7;  4'h7: return 4'hF;
      4'hF: return 4'hE;  4'hE: return 4'hC;  4'hC: return 4'h8;
      default: return 4'h1; // 4'h8
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of sequencer inputs, push the model's expectation,
  // then pop and compare after the edge.
  task automatic doCycle(input logic r, input logic s, input logic ld, input logic [3:0] sd);
    seqExp_t e;
    @(negedge clk);
    rst = r; step = s; seedLoad = ld; seed = sd;
    if (r) begin
      mWin = '0; mGen = '0; mCnt = '0;
    end else if (ld) begin
      mGen = sd;
    end else if (s) begin
      mWin = {fRef(mGen), mWin[4*ROWS-1:4]};
      mGen = fRef(mGen);
      mCnt = mCnt + 8'd1;
    end
    e.win = mWin; e.gen = mGen; e.cnt = mCnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("window", 32'(window), 32'(e.win));
      check("gen_state", 32'(genState), 32'(e.gen));
      check("step_count", 32'(stepCount), 32'(e.cnt));
    end
    rst = 1'b0; step = 1'b0; seedLoad = 1'b0;
  endtask

  initial begin
    combVec_t vecs[16];
    logic [3:0] p;
    logic [15:0] seen;
    int n;
    logic [3:0] chainExp[8];

    // Combinational vectors: every input value.
    for (int i = 0; i < 16; i++) begin
      vecs[i].cp = 4'(i);
      vecs[i].np = fRef(4'(i));
    end
    for (int i = 0; i < 16; i++) begin
      currentPattern = vecs[i].cp;
      #1;
      check($sformatf("comb_f_%0h", vecs[i].cp), 32'(nextPattern), 32'(vecs[i].np));
    end

    // Feedback chain from zero.
    chainExp = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA};
    currentPattern = 4'h0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("chain_%0d", i), 32'(nextPattern), 32'(chainExp[i]));
      currentPattern = nextPattern;
      #1;
    end

    // Period from 0001, bounded at 20 iterations.
    p = 4'h1; seen = '0; n = 0;
    do begin
      currentPattern = p;
      #1;
      p = nextPattern;
      seen[p] = 1'b1;
      n++;
    end while (p != 4'h1 && n < 20);
    check("period_len", 32'(n), 32'd15);
    check("period_seen", 32'(seen), 32'hFFFE);

    // Reset, then four steps.
    doCycle(1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) doCycle(1'b0, 1'b1, 1'b0, 4'h0);
    check("four_steps_window", 32'(window), 32'h9421);
    check("four_steps_gen", 32'(genState), 32'h9);

    // Idle cycle holds everything.
    doCycle(1'b0, 1'b0, 1'b0, 4'h0);

    // Seed load wins over step; window and count hold.
    doCycle(1'b0, 1'b1, 1'b1, 4'hD);
    check("seed_gen", 32'(genState), 32'hD);
    check("seed_window_hold", 32'(window), 32'h9421);
    doCycle(1'b0, 1'b1, 1'b0, 4'h0);
    check("after_seed_row3", 32'(window[15:12]), 32'hA);

    // Run to 20 steps, then reset together with step.
    for (int i = 0; i < 15; i++) doCycle(1'b0, 1'b1, 1'b0, 4'h0);
    check("twenty_steps", 32'(stepCount), 32'd20);
    doCycle(1'b1, 1'b1, 1'b0, 4'h0);
    check("rst_step_window", 32'(window), 32'h0);

    // Seed of zero escapes to 0001 on the next step.
    doCycle(1'b0, 1'b0, 1'b1, 4'h0);
    doCycle(1'b0, 1'b1, 1'b0, 4'h0);
    check("seed_zero_step", 32'(genState), 32'h1);

    // 256 consecutive steps from reset wrap the counter.
    doCycle(1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 256; i++) doCycle(1'b0, 1'b1, 1'b0, 4'h0);
    check("wrap_count", 32'(stepCount), 32'd0);
    check("wrap_gen", 32'(genState), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
